// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder for a pipeline MEM stage.
// Optional misaligned-access checking is enabled by defining MEM_RESPONDER_ALIGN_CHK_EN.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          op_we;
  logic [AW+1:0] op_addr;
  logic [31:0]   op_wdata;
  logic [AW-1:0] idx;
  logic          accept;
  logic          enter_done;
  logic          misaligned;
  logic          commit;

  logic [31:0]   mem [DEPTH_WORDS];

  assign accept = (state_q == IDLE) && req_i;

  // With LATENCY=1 the DONE edge is the accept edge, so the live inputs are the operation.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = we_i;
      op_addr  = addr_i[AW+1:0];
      op_wdata = wdata_i;
    end else begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign idx = op_addr[AW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i[AW+1:0];
      wdata_q <= wdata_i;
    end
  end

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
  logic unused_bits;
  assign unused_bits = ^addr_i[31:AW+2];
  assign misaligned  = (op_addr[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= enter_done && misaligned;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:AW+2], op_addr[1:0]};
  assign misaligned  = 1'b0;
  assign err_o       = 1'b0;
`endif

  // The array has no reset, so an edge seen while rst_i is high must not write it.
  assign commit = enter_done && op_we && !misaligned && !rst_i;

  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem[idx] <= op_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (enter_done && !op_we) begin
      rdata_o <= misaligned ? '0 : mem[idx];
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign rvalid_o = (state_q == DONE);
  assign stall_o  = req_i && (state_q != DONE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// on a LATENCY=3/256-word and a LATENCY=1/16-word instance, checked against an array model.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_b;
  logic        we_b;
  logic [31:0] addr_b;
  logic [31:0] wdata_b;

  logic        req3, ready3, rvalid3, stall3, err3;
  logic [31:0] rdata3;
  logic        req1, ready1, rvalid1, stall1, err1;
  logic [31:0] rdata1;

  logic        o_ready, o_rvalid, o_stall, o_err;
  logic [31:0] o_rdata;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [31:0] mm       [2][256];
  bit          mv       [2][256];
  logic [31:0] rd_m     [2];
  bit          rd_known [2];

  assign req3 = req_b && !sel;
  assign req1 = req_b && sel;

  assign o_ready  = sel ? ready1  : ready3;
  assign o_rvalid = sel ? rvalid1 : rvalid3;
  assign o_stall  = sel ? stall1  : stall3;
  assign o_err    = sel ? err1    : err3;
  assign o_rdata  = sel ? rdata1  : rdata3;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req3),
    .we_i    (we_b),
    .addr_i  (addr_b),
    .wdata_i (wdata_b),
    .ready_o (ready3),
    .rvalid_o(rvalid3),
    .rdata_o (rdata3),
    .stall_o (stall3),
    .err_o   (err3)
  );

  mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req1),
    .we_i    (we_b),
    .addr_i  (addr_b),
    .wdata_i (wdata_b),
    .ready_o (ready1),
    .rvalid_o(rvalid1),
    .rdata_o (rdata1),
    .stall_o (stall1),
    .err_o   (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One complete request on instance s (0: LATENCY=3, 1: LATENCY=1), starting at the next
  // falling edge and ending in the rvalid cycle with req dropped.
  task automatic txn(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input string tag);
    int unsigned lat;
    int unsigned dep;
    int unsigned ix;
    bit          mis;
    lat = s ? 1 : 3;
    dep = s ? 16 : 256;
    ix  = (a >> 2) % dep;
    mis = 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`endif
    if (w) begin
      if (!mis) begin
        mm[s][ix] = d;
        mv[s][ix] = 1'b1;
      end
    end else if (mis) begin
      rd_m[s]     = '0;
      rd_known[s] = 1'b1;
    end else begin
      rd_m[s]     = mm[s][ix];
      rd_known[s] = mv[s][ix];
    end

    @(negedge clk);
    sel     = s;
    req_b   = 1'b1;
    we_b    = w;
    addr_b  = a;
    wdata_b = d;
    for (int unsigned c = 0; c <= lat; c++) begin
      if (c > 0) begin
        @(negedge clk);
        we_b    = 1'($urandom);
        addr_b  = $urandom;
        wdata_b = $urandom;
      end
      #1;
      check($sformatf("%s.ready.c%0d", tag, c), 32'(o_ready), 32'(c == 0));
      check($sformatf("%s.stall.c%0d", tag, c), 32'(o_stall), 32'(c < lat));
      check($sformatf("%s.rvalid.c%0d", tag, c), 32'(o_rvalid), 32'(c == lat));
    end
    check($sformatf("%s.err", tag), 32'(o_err), 32'(mis));
    if (rd_known[s]) check($sformatf("%s.rdata", tag), o_rdata, rd_m[s]);
    req_b = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic        rw;

    rst     = 1'b1;
    sel     = 1'b0;
    req_b   = 1'b0;
    we_b    = 1'b0;
    addr_b  = '0;
    wdata_b = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst.rvalid3", 32'(rvalid3), 32'd0);
    check("rst.rdata3", rdata3, 32'd0);
    check("rst.err3", 32'(err3), 32'd0);
    check("rst.stall3", 32'(stall3), 32'd0);
    check("rst.rvalid1", 32'(rvalid1), 32'd0);
    check("rst.rdata1", rdata1, 32'd0);
    rst = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      rd_m[i]     = '0;
      rd_known[i] = 1'b1;
    end
    @(negedge clk);
    #1;
    check("rel.ready3", 32'(ready3), 32'd1);
    check("rel.ready1", 32'(ready1), 32'd1);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, "st10");
    txn(0, 1'b0, 32'h10, 32'h0, "ld10");
    txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, "st400");
    txn(0, 1'b0, 32'h000, 32'h0, "ld000wrap");

    // Store abandoned by a reset pulse one cycle after accept.
    txn(0, 1'b1, 32'h20, 32'h11, "st20");
    @(negedge clk);
    sel     = 1'b0;
    req_b   = 1'b1;
    we_b    = 1'b1;
    addr_b  = 32'h20;
    wdata_b = 32'h55;
    @(negedge clk);
    req_b = 1'b0;
    rst   = 1'b1;
    #1;
    check("abort.rvalid", 32'(rvalid3), 32'd0);
    check("abort.rdata", rdata3, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      rd_m[i]     = '0;
      rd_known[i] = 1'b1;
    end
    for (int unsigned c = 0; c < 4; c++) begin
      #1;
      check($sformatf("abort.quiet.rvalid.c%0d", c), 32'(rvalid3), 32'd0);
      check($sformatf("abort.quiet.ready.c%0d", c), 32'(ready3), 32'd1);
      @(negedge clk);
    end
    txn(0, 1'b0, 32'h20, 32'h0, "ld20after");

    txn(0, 1'b1, 32'h10, 32'h77, "st10b");
    txn(0, 1'b0, 32'h13, 32'h0, "ld13");

    txn(1, 1'b1, 32'h0, 32'hCAFE0001, "l1.st0");
    txn(1, 1'b1, 32'h4, 32'h12345678, "l1.st4");
    txn(1, 1'b0, 32'h0, 32'h0, "l1.ld0");
    txn(1, 1'b0, 32'h4, 32'h0, "l1.ld4");

    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned n = 0; n < 60; n++) begin
        rw = 1'($urandom_range(0, 1));
        ra = $urandom & 32'hFFFF_F01C;
        if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom_range(1, 3));
        txn(s[0], rw, ra, $urandom, $sformatf("rnd%0d.%0d", s, n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
